matrix_scan: RTL and testbench

MATRIX_SCAN -- requirements
Module: matrix_scan

---
 rtl/matrix_scan.sv | 141 ++++++++++++++
 tb/tb_matrix_scan.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/matrix_scan.sv
// matrix_scan: 8x8 LED matrix row scanner with a tear-free frame buffer.
// Each frame: one LOAD cycle snapshots map0..map7, then rows 0..7 are shown
// for DIV cycles each. Define MATRIX_SCAN_BLANK_EN to insert a DIV-cycle
// dark BLANK period before every row (anti-ghosting).
// Outputs are registered: the values visible in a cycle are those computed
// at the preceding edge from the state that was current at that edge.
module matrix_scan #(
    parameter int unsigned DIV = 4
) (
    input  logic       CLK,
    input  logic       CLR,
    input  logic [7:0] map0,
    input  logic [7:0] map1,
    input  logic [7:0] map2,
    input  logic [7:0] map3,
    input  logic [7:0] map4,
    input  logic [7:0] map5,
    input  logic [7:0] map6,
    input  logic [7:0] map7,
    output logic [7:0] row_n,
    output logic [7:0] col,
    output logic [2:0] row_idx,
    output logic       frame_start,
    output logic [7:0] frame_cnt
);

    localparam int unsigned PW     = 8;
    localparam logic [PW-1:0] DIV_M1 = PW'(DIV - 1);

    typedef enum logic [1:0] {LOAD, BLANK, SHOW} state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   presc_q, presc_d;
    logic [2:0]      scan_q, scan_d;
    logic [7:0]      fbuf_q [8];
    logic [7:0]      map_a  [8];
    logic            load_en;
    logic            tick;
    logic [7:0]      row_n_d, col_d, frame_cnt_d;
    logic [2:0]      row_idx_d;
    logic            frame_start_d;

    // Gather the playfield rows into an indexable array
    assign map_a[0] = map0;
    assign map_a[1] = map1;
    assign map_a[2] = map2;
    assign map_a[3] = map3;
    assign map_a[4] = map4;
    assign map_a[5] = map5;
    assign map_a[6] = map6;
    assign map_a[7] = map7;

    assign tick = (presc_q == DIV_M1);

    // State, counters and registered outputs
    always_ff @(posedge CLK) begin
        if (!CLR) begin
            state_q     <= LOAD;
            presc_q     <= '0;
            scan_q      <= '0;
            row_n       <= 8'hFF;
            col         <= 8'h00;
            row_idx     <= '0;
            frame_start <= 1'b0;
            frame_cnt   <= '0;
        end else begin
            state_q     <= state_d;
            presc_q     <= presc_d;
            scan_q      <= scan_d;
            row_n       <= row_n_d;
            col         <= col_d;
            row_idx     <= row_idx_d;
            frame_start <= frame_start_d;
            frame_cnt   <= frame_cnt_d;
        end
    end

    // Frame buffer: written only in LOAD so a frame never tears
    always_ff @(posedge CLK) begin
        for (int i = 0; i < 8; i++) begin
            if (!CLR)
                fbuf_q[i] <= 8'h00;
            else if (load_en)
                fbuf_q[i] <= map_a[i];
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d       = state_q;
        presc_d       = presc_q;
        scan_d        = scan_q;
        load_en       = 1'b0;
        row_n_d       = 8'hFF;
        col_d         = 8'h00;
        row_idx_d     = scan_q;
        frame_start_d = 1'b0;
        frame_cnt_d   = frame_cnt;

        case (state_q)
            LOAD: begin
                load_en       = 1'b1;
                frame_start_d = 1'b1;
                frame_cnt_d   = frame_cnt + 8'd1;
                presc_d       = '0;
                scan_d        = '0;
                row_idx_d     = '0;
`ifdef MATRIX_SCAN_BLANK_EN
                state_d       = BLANK;
`else
                state_d       = SHOW;
`endif
            end
            BLANK: begin
                presc_d = tick ? '0 : presc_q + PW'(1);
                if (tick)
                    state_d = SHOW;
            end
            SHOW: begin
                row_n_d = ~(8'h01 << scan_q);
                col_d   = fbuf_q[scan_q];
                presc_d = tick ? '0 : presc_q + PW'(1);
                if (tick) begin
                    if (scan_q == 3'd7) begin
                        scan_d  = '0;
                        state_d = LOAD;
                    end else begin
                        scan_d  = scan_q + 3'd1;
`ifdef MATRIX_SCAN_BLANK_EN
                        state_d = BLANK;
`else
                        state_d = SHOW;
`endif
                    end
                end
            end
            default: state_d = LOAD;
        endcase
    end

endmodule

// File: tb/tb_matrix_scan.sv
// tb_matrix_scan: directed checks of matrix_scan with DIV=4 and DIV=1.
module tb_matrix_scan;

`ifdef MATRIX_SCAN_BLANK_EN
    localparam int BLK = 1;
`else
    localparam int BLK = 0;
`endif
    localparam int DIV_A = 4;

    logic       clk;
    logic       clr;
    logic [7:0] map0, map1, map2, map3, map4, map5, map6, map7;

    logic [7:0] row_n, col, frame_cnt;
    logic [2:0] row_idx;
    logic       fs;

    logic [7:0] row_n1, col1, frame_cnt1;
    logic [2:0] row_idx1;
    logic       fs1;

    int n_run  = 0;
    int n_fail = 0;

    matrix_scan #(.DIV(DIV_A)) dut (
        .CLK(clk), .CLR(clr),
        .map0(map0), .map1(map1), .map2(map2), .map3(map3),
        .map4(map4), .map5(map5), .map6(map6), .map7(map7),
        .row_n(row_n), .col(col), .row_idx(row_idx),
        .frame_start(fs), .frame_cnt(frame_cnt)
    );

    matrix_scan #(.DIV(1)) dut1 (
        .CLK(clk), .CLR(clr),
        .map0(map0), .map1(map1), .map2(map2), .map3(map3),
        .map4(map4), .map5(map5), .map6(map6), .map7(map7),
        .row_n(row_n1), .col(col1), .row_idx(row_idx1),
        .frame_start(fs1), .frame_cnt(frame_cnt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %02h expected %02h at %0t", tag, got, exp, $time);
        end
    endtask

    // Walks one DIV=4 frame starting from the LOAD cycle; optionally pokes map3 during row 1
    task automatic scan_frame(input logic [7:0][7:0] rows, input logic [7:0] cnt, input bit poke);
        logic [7:0] one;
        logic [7:0] exp_rn;
        one = 8'h01;
        @(negedge clk);
        check("load_fs",    8'(fs),      8'h01);
        check("load_cnt",   frame_cnt,   cnt);
        check("load_row_n", row_n,       8'hFF);
        check("load_col",   col,         8'h00);
        check("load_idx",   8'(row_idx), 8'h00);
        for (int r = 0; r < 8; r++) begin
            for (int k = 0; k < BLK * DIV_A; k++) begin
                @(negedge clk);
                check("blank_row_n", row_n,       8'hFF);
                check("blank_col",   col,         8'h00);
                check("blank_idx",   8'(row_idx), 8'(r));
                check("blank_fs",    8'(fs),      8'h00);
            end
            exp_rn = ~(one << r);
            for (int k = 0; k < DIV_A; k++) begin
                @(negedge clk);
                check("show_row_n", row_n,       exp_rn);
                check("show_col",   col,         rows[r]);
                check("show_idx",   8'(row_idx), 8'(r));
                check("show_fs",    8'(fs),      8'h00);
                if (poke && r == 1 && k == 0)
                    map3 = 8'hFF;
            end
        end
    endtask

    initial begin
        logic [7:0][7:0] rows_a;
        logic [7:0][7:0] rows_b;
        bit              found;
        logic            fs_seen;

        rows_a = '0;
        rows_a[0] = 8'h81;
        rows_a[7] = 8'h18;
        rows_b = rows_a;
        rows_b[3] = 8'hFF;

        clr  = 1'b0;
        map0 = 8'h81; map1 = 8'h00; map2 = 8'h00; map3 = 8'h00;
        map4 = 8'h00; map5 = 8'h00; map6 = 8'h00; map7 = 8'h18;

        // Reset held for three cycles: all outputs idle
        @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_row_n", row_n,       8'hFF);
            check("rst_col",   col,         8'h00);
            check("rst_fs",    8'(fs),      8'h00);
            check("rst_cnt",   frame_cnt,   8'h00);
            check("rst_idx",   8'(row_idx), 8'h00);
        end
        clr = 1'b1;

        // Frame 1, frame 2 with a mid-frame map3 change, frame 3 shows it
        scan_frame(rows_a, 8'd1, 1'b0);
        scan_frame(rows_a, 8'd2, 1'b1);
        scan_frame(rows_b, 8'd3, 1'b0);

        // Reset pulse while row 5 is shown
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clk);
            if (row_idx == 3'd5 && row_n == 8'hDF) found = 1'b1;
        end
        check("wait_row5", 8'(found), 8'h01);
        clr = 1'b0;
        @(negedge clk);
        check("abort_row_n", row_n,       8'hFF);
        check("abort_col",   col,         8'h00);
        check("abort_idx",   8'(row_idx), 8'h00);
        check("abort_cnt",   frame_cnt,   8'h00);
        check("abort_fs",    8'(fs),      8'h00);
        clr = 1'b1;
        scan_frame(rows_b, 8'd1, 1'b0);

        // DIV=1 instance: 256 frames, counter wraps, fixed frame period
        clr = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("d1_rst_cnt", frame_cnt1, 8'h00);
        clr = 1'b1;
        for (int f = 0; f < 256; f++) begin
            @(negedge clk);
            check("d1_fs",  8'(fs1),    8'h01);
            check("d1_cnt", frame_cnt1, 8'(f + 1));
            fs_seen = 1'b0;
            for (int k = 0; k < 8 * (1 + BLK); k++) begin
                @(negedge clk);
                fs_seen = fs_seen | fs1;
            end
            check("d1_gap_fs", 8'(fs_seen), 8'h00);
        end

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
